// File: rtl/clock_ctrl_pkg.sv
// Shared types and field limits for the binary clock time-set controller.
// Holds the set-FSM state encoding plus hour/minute increment-with-wrap helpers.
package clock_ctrl_pkg;

  localparam int HOURS_W     = 5;
  localparam int MINUTES_W   = 6;
  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } set_state_e;

  // ">=" rather than "==" so an out-of-range captured value wraps to 0 on the first increment
  function automatic logic [HOURS_W-1:0] next_hours(input logic [HOURS_W-1:0] h);
    return (h >= HOURS_W'(HOURS_MAX)) ? '0 : h + HOURS_W'(1);
  endfunction

  function automatic logic [MINUTES_W-1:0] next_minutes(input logic [MINUTES_W-1:0] m);
    return (m >= MINUTES_W'(MINUTES_MAX)) ? '0 : m + MINUTES_W'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, consecutive-sample debounce filter and one-cycle press pulse.
// The debounced level port only exists when CLOCK_SET_AUTO_REPEAT_EN is defined.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  output logic level,
`endif
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync0_q;
  logic             sync1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_d1_q;
  logic             armed_q;
  logic             press_q;

  // Synchronizer keeps sampling through reset, so a button held across reset
  // is already seen high when reset drops and never arms on the way in.
  always_ff @(posedge clk) begin
    sync0_q <= raw;
    sync1_q <= sync0_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      armed_q    <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      level_d1_q <= level_q;
      press_q    <= level_q & ~level_d1_q & armed_q;
      // Arm only after a settled release has been observed
      if (!sync1_q && !level_q) begin
        armed_q <= 1'b1;
      end
      if (sync1_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync1_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = press_q;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  assign level = level_q;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-set controller: RUN -> SET_H -> SET_M -> COMMIT with shadow edit,
// one-cycle counter load, run gating and blink mask. Optional auto-repeat: CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_BITS      = 8
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_mode,
  input  logic                 btn_inc,
  input  logic [HOURS_W-1:0]   hours_in,
  input  logic [MINUTES_W-1:0] minutes_in,
  output logic                 load,
  output logic [HOURS_W-1:0]   hours_load,
  output logic [MINUTES_W-1:0] minutes_load,
  output logic                 run_en,
  output logic [1:0]           blink_mask,
  output logic [1:0]           state
);

  set_state_e             state_q, state_d;
  logic [HOURS_W-1:0]     sh_h_q, sh_h_d;
  logic [MINUTES_W-1:0]   sh_m_q, sh_m_d;
  logic [HOURS_W-1:0]     hours_load_q;
  logic [MINUTES_W-1:0]   minutes_load_q;
  logic [BLINK_BITS-1:0]  blink_q;
  logic                   blink_phase;
  logic                   mode_press;
  logic                   inc_press;
  logic                   inc_evt;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  logic mode_level;
  logic inc_level;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  logic             rpt_active_q;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic             in_set;
  logic             rpt_fire;

  assign in_set   = (state_q == SET_H) || (state_q == SET_M);
  // rpt_cnt_q counts cycles since the initial press pulse; after each repeat it is
  // rewound so the next one lands REPEAT_PERIOD cycles later.
  assign rpt_fire = rpt_active_q && inc_level && in_set &&
                    (rpt_cnt_q == RPT_W'(REPEAT_DELAY));
  assign inc_evt  = inc_press | rpt_fire;

  always_ff @(posedge clk) begin
    if (rst || !inc_level || !in_set || (state_d != state_q)) begin
      rpt_active_q <= 1'b0;
      rpt_cnt_q    <= '0;
    end else if (inc_press) begin
      rpt_active_q <= 1'b1;
      rpt_cnt_q    <= RPT_W'(1);
    end else if (rpt_fire) begin
      rpt_cnt_q <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    end else if (rpt_active_q) begin
      rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
    end
  end

  logic unused_mode_level;
  assign unused_mode_level = mode_level;
`else
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .press (mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_inc),
    .press (inc_press)
  );

  assign inc_evt = inc_press;
`endif

  // Next state and shadow edits; a mode press in the same cycle as an inc wins
  always_comb begin
    state_d = state_q;
    sh_h_d  = sh_h_q;
    sh_m_d  = sh_m_q;
    case (state_q)
      RUN: begin
        if (mode_press) begin
          sh_h_d  = hours_in;
          sh_m_d  = minutes_in;
          state_d = SET_H;
        end
      end
      SET_H: begin
        if (mode_press) begin
          state_d = SET_M;
        end else if (inc_evt) begin
          sh_h_d = next_hours(sh_h_q);
        end
      end
      SET_M: begin
        if (mode_press) begin
          state_d = COMMIT;
        end else if (inc_evt) begin
          sh_m_d = next_minutes(sh_m_q);
        end
      end
      COMMIT: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      sh_h_q         <= '0;
      sh_m_q         <= '0;
      hours_load_q   <= '0;
      minutes_load_q <= '0;
      blink_q        <= '0;
    end else begin
      state_q <= state_d;
      sh_h_q  <= sh_h_d;
      sh_m_q  <= sh_m_d;
      blink_q <= blink_q + BLINK_BITS'(1);
      // Latch the committed values on entry to COMMIT so they hold afterwards
      if (state_q == SET_M && mode_press) begin
        hours_load_q   <= sh_h_q;
        minutes_load_q <= sh_m_q;
      end
    end
  end

  assign blink_phase = blink_q[BLINK_BITS-1];

  always_comb begin
    blink_mask = 2'b00;
    case (state_q)
      SET_H:   blink_mask = {blink_phase, 1'b0};
      SET_M:   blink_mask = {1'b0, blink_phase};
      default: blink_mask = 2'b00;
    endcase
  end

  assign load         = (state_q == COMMIT);
  assign run_en       = (state_q == RUN);
  assign hours_load   = hours_load_q;
  assign minutes_load = minutes_load_q;
  assign state        = state_q;

endmodule
